// File: rtl/park_entry_encrypt_pkg.sv
// Shared constants and FSM encoding for the entry-gate encryptor.
package park_entry_encrypt_pkg;

  localparam int              PE_ID_W      = 3;
  localparam int              PE_SPOTS     = 2 ** PE_ID_W;
  localparam logic [PE_ID_W-1:0] PE_LFSR_SEED = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ISSUE  = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_lfsr.sv
// Free-running 3-bit Fibonacci LFSR; maximal length (period 7), never reaches 0.
module pattern_lfsr #(
  parameter logic [2:0] SEED = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] lfsr
);

  // Advance every cycle regardless of what the gate FSM is doing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
  end

endmodule

// File: rtl/park_entry_encrypt.sv
// Entry gate: reserves a free bay, issues token = bay ^ pattern, tracks occupancy.
import park_entry_encrypt_pkg::*;

module park_entry_encrypt #(
  parameter int              SPOTS     = PE_SPOTS,
  parameter int              ID_W      = PE_ID_W,
  parameter logic [ID_W-1:0] LFSR_SEED = PE_LFSR_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enter,
  input  logic            token_ack,
  input  logic            exit_valid,
  input  logic [ID_W-1:0] exit_spot,
  output logic [ID_W-1:0] token,
  output logic [ID_W-1:0] pattern,
  output logic [ID_W-1:0] park_number,
  output logic            token_valid,
  output logic            reject,
  output logic            err_release,
  output logic            full,
  output logic [ID_W:0]   count
);

  state_t            state, state_nxt;
  logic [SPOTS-1:0]  occ, occ_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W:0]     count_nxt;
  logic [ID_W-1:0]   lfsr;

  logic bay_free, ack_fire, rel_ok, rel_bad;

  pattern_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .lfsr (lfsr)
  );

  assign full     = (count == (ID_W+1)'(SPOTS));
  assign bay_free = !occ[ptr];
  assign ack_fire = (state == ISSUE) && token_ack;
  // The reserved bay stays free until ack, so releasing it counts as an error.
  assign rel_ok   = exit_valid &&  occ[exit_spot];
  assign rel_bad  = exit_valid && !occ[exit_spot];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; SEARCH is entered only when a free bay exists.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enter && !full) state_nxt = SEARCH;
      SEARCH:  if (bay_free)       state_nxt = ISSUE;
      ISSUE:   if (token_ack)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Occupancy and count: ack sets the reserved bit, a valid release clears another.
  always_comb begin
    occ_nxt = occ;
    if (rel_ok)   occ_nxt[exit_spot]   = 1'b0;
    if (ack_fire) occ_nxt[park_number] = 1'b1;
    count_nxt = count + (ID_W+1)'(ack_fire) - (ID_W+1)'(rel_ok);
  end

  // Datapath: scan pointer, token capture, map/count update, status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ         <= '0;
      count       <= '0;
      ptr         <= '0;
      token       <= '0;
      pattern     <= '0;
      park_number <= '0;
      token_valid <= 1'b0;
      reject      <= 1'b0;
      err_release <= 1'b0;
    end else begin
      reject      <= (state == IDLE) && enter && full;
      err_release <= rel_bad;
      occ         <= occ_nxt;
      count       <= count_nxt;
      if (state == SEARCH) begin
        if (bay_free) begin
          park_number <= ptr;
          pattern     <= lfsr;
          token       <= ptr ^ lfsr;
          token_valid <= 1'b1;
        end else begin
          ptr <= ptr + ID_W'(1);
        end
      end
      if (ack_fire) begin
        token_valid <= 1'b0;
        ptr         <= park_number + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_park_entry_encrypt.sv
// Self-checking bench: occupancy model + scoreboard of expected bays, release vector table.
module tb_park_entry_encrypt;

  logic       clk, rst_n, enter, token_ack, exit_valid;
  logic [2:0] exit_spot, token, pattern, park_number;
  logic       token_valid, reject, err_release, full;
  logic [3:0] count;

  park_entry_encrypt dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .token_ack(token_ack),
    .exit_valid(exit_valid), .exit_spot(exit_spot), .token(token),
    .pattern(pattern), .park_number(park_number), .token_valid(token_valid),
    .reject(reject), .err_release(err_release), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pattern generator: m_lfsr_q is the value present before the last edge.
  logic [2:0] m_lfsr, m_lfsr_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr   <= 3'b101;
      m_lfsr_q <= 3'b101;
    end else begin
      m_lfsr   <= {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
      m_lfsr_q <= m_lfsr;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_occ;
  int         m_cnt;
  int         m_ptr;
  logic [2:0] sb[$];

  typedef struct {
    logic [2:0] spot;
    logic       exp_err;
    logic [3:0] exp_cnt;
  } rel_vec_t;
  rel_vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [2:0] model_find();
    int i = m_ptr;
    for (int k = 0; k < 8; k++) begin
      if (!m_occ[i]) return 3'(i);
      i = (i + 1) % 8;
    end
    return 3'(m_ptr);
  endfunction

  task automatic model_reset();
    m_occ = '0; m_cnt = 0; m_ptr = 0;
    sb.delete();
  endtask

  // Enter, wait (bounded) for the token, check it against the scoreboard and pattern model.
  task automatic request(output logic [2:0] p, output logic [2:0] pat);
    int n = 0;
    logic [2:0] e;
    e = model_find();
    sb.push_back(e);
    enter = 1'b1; @(negedge clk); enter = 1'b0;
    while (!token_valid && n < 12) begin @(negedge clk); n++; end
    chk("issue_seen", token_valid, 1);
    p = e; pat = m_lfsr_q;
    if (token_valid && sb.size() > 0) begin
      p = sb.pop_front();
      chk("park_number", park_number, p);
      chk("pattern", pattern, pat);
      chk("token", token, p ^ pat);
    end else begin
      sb.delete();
    end
  endtask

  task automatic ack(input logic [2:0] p);
    token_ack = 1'b1; @(negedge clk); token_ack = 1'b0;
    m_occ[p] = 1'b1; m_cnt++; m_ptr = (p + 1) % 8;
  endtask

  task automatic release_bay(input logic [2:0] s);
    exit_valid = 1'b1; exit_spot = s; @(negedge clk); exit_valid = 1'b0;
    if (m_occ[s]) begin m_occ[s] = 1'b0; m_cnt--; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tv"},    token_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_tok"},   token, 0);
    chk({tag, "_pat"},   pattern, 0);
    chk({tag, "_park"},  park_number, 0);
    chk({tag, "_rej"},   reject, 0);
    chk({tag, "_err"},   err_release, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p, pat, exp_pat;

    // Release vectors applied to a full map whose scan pointer sits at 6.
    tbl[0] = '{3'd3, 1'b0, 4'd7};
    tbl[1] = '{3'd3, 1'b1, 4'd7};
    tbl[2] = '{3'd6, 1'b0, 4'd6};
    tbl[3] = '{3'd6, 1'b1, 4'd6};
    tbl[4] = '{3'd3, 1'b1, 4'd6};

    rst_n = 1'b0; enter = 0; token_ack = 0; exit_valid = 0; exit_spot = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill all eight bays in order.
    for (int i = 0; i < 8; i++) begin
      request(p, pat);
      chk("fill_order", p, i);
      ack(p);
      chk("fill_count", count, m_cnt);
    end
    chk("full_count", count, 8);
    chk("full_flag", full, 1);

    // Enter while full: one-cycle reject, no token.
    enter = 1'b1; @(negedge clk); enter = 1'b0;
    chk("reject_pulse", reject, 1);
    chk("reject_no_tv", token_valid, 0);
    @(negedge clk);
    chk("reject_clear", reject, 0);
    repeat (3) @(negedge clk);
    chk("reject_idle_tv", token_valid, 0);

    // Release bay 5 from a full map, then the next car gets bay 5.
    release_bay(3'd5);
    chk("rel5_err", err_release, 0);
    chk("rel5_count", count, 7);
    request(p, pat);
    chk("reuse_bay5", p, 5);
    chk("token_xor", token ^ pattern, 5);
    ack(p);
    chk("refull_count", count, 8);

    // Table of releases, valid and double/free.
    for (int i = 0; i < 5; i++) begin
      release_bay(tbl[i].spot);
      chk($sformatf("tbl%0d_err", i), err_release, tbl[i].exp_err);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
      @(negedge clk);
      chk($sformatf("tbl%0d_err_clr", i), err_release, 0);
    end

    // Hold ISSUE without ack: outputs stay at the captured values.
    request(p, pat);
    chk("hold_bay", p, 6);
    exp_pat = pat;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_tv", token_valid, 1);
      chk("hold_park", park_number, p);
      chk("hold_pat", pattern, exp_pat);
      chk("hold_tok", token, p ^ exp_pat);
    end
    // Releasing the reserved (still free) bay is an error.
    release_bay(p);
    chk("resv_rel_err", err_release, 1);
    chk("resv_rel_count", count, 6);
    chk("resv_rel_tv", token_valid, 1);
    // Ack plus release of bay 1 in the same cycle: count unchanged.
    token_ack = 1'b1; exit_valid = 1'b1; exit_spot = 3'd1;
    @(negedge clk);
    token_ack = 1'b0; exit_valid = 1'b0;
    m_occ[p] = 1'b1; m_occ[1] = 1'b0; m_ptr = (p + 1) % 8;
    chk("ackrel_count", count, 6);
    chk("ackrel_err", err_release, 0);
    chk("ackrel_tv", token_valid, 0);

    // Reset while scanning.
    enter = 1'b1; @(negedge clk); enter = 1'b0;
    chk("search_tv", token_valid, 0);
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst_search");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tv", token_valid, 0);

    // Reset while a token is pending.
    request(p, pat);
    chk("post_rst_bay0", p, 0);
    ack(p);
    request(p, pat);
    chk("pending_bay1", p, 1);
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst_issue");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    // Occupancy was cleared: bay 0 is free again.
    request(p, pat);
    chk("cleared_bay0", p, 0);
    ack(p);
    chk("cleared_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
